// File: rtl/drs_pkg.sv
// Shared types and field constants for the DRS readout FIFO event unpacker.
package drs_pkg;

  localparam int DEPTH_W = 13;

  localparam logic [15:0] HDR0_RSV_MASK = 16'hFFFE;

  localparam int HDR1_CH_HI   = 11;
  localparam int HDR1_CH_LO   = 10;
  localparam int HDR1_CELL_HI = 9;
  localparam int HDR1_CELL_LO = 0;
  localparam int RSV_HI       = 15;
  localparam int RSV_LO       = 12;

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    SAMP_A,
    SAMP_B
  } st_t;

  typedef struct packed {
    logic [RSV_LO-1:0]  data;
    logic               ch;
    logic [DEPTH_W-1:0] idx;
    logic               last;
  } samp_t;

endpackage

// File: rtl/drs_event_unpacker_if.sv
// Sample stream toward the event builder (valid/ready).
interface drs_event_unpacker_if;
  import drs_pkg::*;

  logic               OUT_VALID;
  logic               OUT_READY;
  logic [11:0]        OUT_DATA;
  logic               OUT_CH;
  logic [DEPTH_W-1:0] OUT_IDX;
  logic               OUT_LAST;

  modport master (
    output OUT_VALID, OUT_DATA, OUT_CH,
    output OUT_IDX, OUT_LAST,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID, OUT_DATA, OUT_CH,
    input  OUT_IDX, OUT_LAST,
    output OUT_READY
  );

endinterface

// File: rtl/drs_word_skid.sv
// Byte-to-word assembler (low byte first) plus output register and one-word skid.
module drs_word_skid
  import drs_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        FIFO_EMPTY,
  input  logic        FIFO_VALID,
  input  logic [7:0]  FIFO_DOUT,
  output logic        FIFO_RD_EN,
  input  logic        flush,
  output logic        w_vld,
  output logic [15:0] w_data,
  output logic        mid_word,
  input  logic        push,
  input  samp_t       push_s,
  drs_event_unpacker_if.master out_if
);

  logic       hi_ph;
  logic [7:0] lo_q;
  samp_t      out_q;
  samp_t      skd_q;
  logic       out_v;
  logic       skd_v;
  logic       xfer;

  assign w_vld      = FIFO_VALID & hi_ph;
  assign w_data     = {FIFO_DOUT, lo_q};
  assign mid_word   = hi_ph;
  // Read stalls only on a full skid; one in-flight low byte still lands in lo_q.
  assign FIFO_RD_EN = ~FIFO_EMPTY & ~skd_v;
  assign xfer       = out_v & out_if.OUT_READY;

  assign out_if.OUT_VALID = out_v;
  assign out_if.OUT_DATA  = out_q.data;
  assign out_if.OUT_CH    = out_q.ch;
  assign out_if.OUT_IDX   = out_q.idx;
  assign out_if.OUT_LAST  = out_q.last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi_ph <= 1'b0;
      lo_q  <= '0;
      out_q <= '0;
      skd_q <= '0;
      out_v <= 1'b0;
      skd_v <= 1'b0;
    end else begin
      if (flush) begin
        hi_ph <= 1'b0;
      end else if (FIFO_VALID) begin
        if (!hi_ph) lo_q <= FIFO_DOUT;
        hi_ph <= ~hi_ph;
      end

      if (!out_v || xfer) begin
        out_v <= skd_v | push;
        if (skd_v) begin
          out_q <= skd_q;
          skd_v <= push;
          if (push) skd_q <= push_s;
        end else if (push) begin
          out_q <= push_s;
        end
      end else if (push) begin
        skd_v <= 1'b1;
        skd_q <= push_s;
      end

      if (flush) skd_v <= 1'b0;
    end
  end

endmodule

// File: rtl/drs_event_unpacker.sv
// DRS readout FIFO event parser: header decode and A/B sample stream.
// DRS_UNPACK_TIMEOUT_EN adds a mid-event byte-starvation watchdog.
module drs_event_unpacker
  import drs_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DEPTH_W-1:0] READDEPTH,
  input  logic               FIFO_EMPTY,
  input  logic               FIFO_VALID,
  input  logic [7:0]         FIFO_DOUT,
  output logic               FIFO_RD_EN,
  output logic               HDR_VALID,
  output logic               HDR_STOPCH_FLAG,
  output logic [1:0]         HDR_STOPCH,
  output logic [9:0]         HDR_STOPCELL,
  output logic               FMT_ERR,
  output logic [CNT_W-1:0]   EVT_CNT,
  drs_event_unpacker_if.master out_if
);

  st_t                st;
  logic [DEPTH_W-1:0] d_q;
  logic [DEPTH_W-1:0] idx_q;
  logic               flag_q;
  logic               w_vld;
  logic [15:0]        w;
  logic               mid_word;
  logic               push;
  logic               flush;
  logic               at_end;
  logic               rsv_bad;
  samp_t              push_s;

  drs_word_skid u_skid (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_VALID (FIFO_VALID),
    .FIFO_DOUT  (FIFO_DOUT),
    .FIFO_RD_EN (FIFO_RD_EN),
    .flush      (flush),
    .w_vld      (w_vld),
    .w_data     (w),
    .mid_word   (mid_word),
    .push       (push),
    .push_s     (push_s),
    .out_if     (out_if)
  );

  assign at_end  = idx_q == d_q - DEPTH_W'(1);
  assign rsv_bad = |w[RSV_HI:RSV_LO];
  assign push    = w_vld & ((st == SAMP_A) | (st == SAMP_B));

  always_comb begin
    push_s      = '0;
    push_s.data = w[RSV_LO-1:0];
    push_s.ch   = st == SAMP_B;
    push_s.idx  = idx_q;
    push_s.last = (st == SAMP_B) & at_end;
  end

`ifdef DRS_UNPACK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            busy;

  assign busy  = (st != HDR0) | mid_word;
  assign flush = busy & ~FIFO_VALID &
                 (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_q <= '0;
    end else if (FIFO_VALID || !busy || flush) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  logic unused_to;

  assign flush     = 1'b0;
  assign unused_to = (|TIMEOUT_CYC) | mid_word;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st              <= HDR0;
      d_q             <= '0;
      idx_q           <= '0;
      flag_q          <= 1'b0;
      HDR_VALID       <= 1'b0;
      HDR_STOPCH_FLAG <= 1'b0;
      HDR_STOPCH      <= '0;
      HDR_STOPCELL    <= '0;
      FMT_ERR         <= 1'b0;
      EVT_CNT         <= '0;
    end else begin
      HDR_VALID <= 1'b0;
      if (w_vld) begin
        unique case (st)
          HDR0: begin
            if ((w & HDR0_RSV_MASK) == 16'h0000) begin
              flag_q <= w[0];
              d_q    <= READDEPTH;
              st     <= HDR1;
            end else begin
              FMT_ERR <= 1'b1;
            end
          end
          HDR1: begin
            // Header outputs swap together so they hold until the next pulse.
            HDR_STOPCH_FLAG <= flag_q;
            HDR_STOPCH      <= w[HDR1_CH_HI:HDR1_CH_LO];
            HDR_STOPCELL    <= w[HDR1_CELL_HI:HDR1_CELL_LO];
            HDR_VALID       <= 1'b1;
            idx_q           <= '0;
            if (rsv_bad) FMT_ERR <= 1'b1;
            if (d_q == '0) begin
              EVT_CNT <= EVT_CNT + CNT_W'(1);
              st      <= HDR0;
            end else begin
              st <= SAMP_A;
            end
          end
          SAMP_A: begin
            if (rsv_bad) FMT_ERR <= 1'b1;
            if (at_end) begin
              st    <= SAMP_B;
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + DEPTH_W'(1);
            end
          end
          SAMP_B: begin
            if (rsv_bad) FMT_ERR <= 1'b1;
            if (at_end) begin
              EVT_CNT <= EVT_CNT + CNT_W'(1);
              st      <= HDR0;
            end else begin
              idx_q <= idx_q + DEPTH_W'(1);
            end
          end
          default: st <= HDR0;
        endcase
      end
      if (flush) begin
        st      <= HDR0;
        FMT_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_drs_event_unpacker.sv
// Directed bench for drs_event_unpacker: byte FIFO model, sample capture, assertions.
module tb_drs_event_unpacker;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [12:0] READDEPTH = 13'd4;
  logic        FIFO_EMPTY = 1'b1;
  logic        FIFO_VALID = 1'b0;
  logic [7:0]  FIFO_DOUT = 8'h00;
  logic        FIFO_RD_EN;
  logic        HDR_VALID;
  logic        HDR_STOPCH_FLAG;
  logic [1:0]  HDR_STOPCH;
  logic [9:0]  HDR_STOPCELL;
  logic        FMT_ERR;
  logic [15:0] EVT_CNT;

  drs_event_unpacker_if u_if ();

  drs_event_unpacker dut (
    .CLK             (CLK),
    .RST             (RST),
    .READDEPTH       (READDEPTH),
    .FIFO_EMPTY      (FIFO_EMPTY),
    .FIFO_VALID      (FIFO_VALID),
    .FIFO_DOUT       (FIFO_DOUT),
    .FIFO_RD_EN      (FIFO_RD_EN),
    .HDR_VALID       (HDR_VALID),
    .HDR_STOPCH_FLAG (HDR_STOPCH_FLAG),
    .HDR_STOPCH      (HDR_STOPCH),
    .HDR_STOPCELL    (HDR_STOPCELL),
    .FMT_ERR         (FMT_ERR),
    .EVT_CNT         (EVT_CNT),
    .out_if          (u_if)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  fifo[$];
  logic [26:0] got[$];
  int          hdr_cnt;
  int          hdr_cyc;
  int          first_out_cyc;
  int          cyc = 0;
  int          stall_err;
  logic        hflag;
  logic [1:0]  hch;
  logic [9:0]  hcell;
  logic        prev_stall;
  logic [26:0] prev_b;
  bit          rnd_stall = 0;
  bit          mid_rd = 0;

  logic [7:0] ev_main [20] = '{
    8'h01, 8'h00, 8'h34, 8'h0E,
    8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h04, 8'h44, 8'h05,
    8'h55, 8'h06, 8'h66, 8'h07, 8'h77, 8'h08, 8'h88, 8'h09
  };

  logic [11:0] exp_main [8] = '{
    12'h211, 12'h322, 12'h433, 12'h544,
    12'h655, 12'h766, 12'h877, 12'h988
  };

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] bund();
    return {u_if.OUT_DATA, u_if.OUT_CH, u_if.OUT_IDX, u_if.OUT_LAST};
  endfunction

  task automatic load_main();
    for (int i = 0; i < 20; i++) fifo.push_back(ev_main[i]);
  endtask

  task automatic clr();
    hdr_cnt       = 0;
    hdr_cyc       = -1;
    first_out_cyc = -1;
    stall_err     = 0;
    prev_stall    = 1'b0;
    got.delete();
  endtask

  task automatic tick();
    logic rd;
    @(negedge CLK);
    cyc++;
    rd = FIFO_RD_EN;
    if (HDR_VALID) begin
      hdr_cnt++;
      hdr_cyc = cyc;
      hflag   = HDR_STOPCH_FLAG;
      hch     = HDR_STOPCH;
      hcell   = HDR_STOPCELL;
    end
    if (prev_stall && (!u_if.OUT_VALID || bund() !== prev_b)) stall_err++;
    if (u_if.OUT_VALID && first_out_cyc < 0) first_out_cyc = cyc;
    if (u_if.OUT_VALID && u_if.OUT_READY) got.push_back(bund());
    prev_stall = u_if.OUT_VALID && !u_if.OUT_READY;
    prev_b     = bund();
    if (mid_rd && hdr_cnt > 0) READDEPTH = 13'd2;
    @(posedge CLK);
    #1;
    FIFO_VALID = rd && fifo.size() > 0;
    if (FIFO_VALID) FIFO_DOUT = fifo.pop_front();
    FIFO_EMPTY = (fifo.size() == 0) ||
                 (rnd_stall && $urandom_range(0, 1) == 1);
    u_if.OUT_READY = rnd_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
  endtask

  task automatic run(int budget);
    int idle = 0;
    int n = 0;
    clr();
    FIFO_EMPTY = (fifo.size() == 0);
    while (idle < 4 && n < budget) begin
      tick();
      n++;
      if (fifo.size() == 0 && !FIFO_VALID && !u_if.OUT_VALID) idle++;
      else idle = 0;
    end
    chk("run_budget", idle, 4);
  endtask

  task automatic check_main(string tag);
    logic [26:0] e;
    chk($sformatf("%s_hdrcnt", tag), hdr_cnt, 1);
    chk($sformatf("%s_flag", tag), hflag, 1);
    chk($sformatf("%s_stopch", tag), hch, 3);
    chk($sformatf("%s_stopcell", tag), hcell, 10'h234);
    chk($sformatf("%s_hdr_first", tag), hdr_cyc < first_out_cyc, 1);
    chk($sformatf("%s_nsamp", tag), got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      e = {exp_main[i], 1'(i >= 4), 13'(i % 4), 1'(i == 7)};
      chk($sformatf("%s_s%0d", tag, i),
          (i < got.size()) ? got[i] : 27'h7FFFFFF, e);
    end
  endtask

  initial begin
    u_if.OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out", bund(), 0);
    chk("rst_ovalid", u_if.OUT_VALID, 0);
    chk("rst_hdr", {HDR_VALID, HDR_STOPCH_FLAG, HDR_STOPCH, HDR_STOPCELL}, 0);
    chk("rst_err_cnt", {FMT_ERR, EVT_CNT}, 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    load_main();
    run(300);
    check_main("ev1");
    chk("ev1_cnt", EVT_CNT, 1);
    chk("ev1_err", FMT_ERR, 0);

    rnd_stall = 1;
    mid_rd    = 1;
    load_main();
    run(3000);
    rnd_stall      = 0;
    mid_rd         = 0;
    READDEPTH      = 13'd4;
    u_if.OUT_READY = 1'b1;
    check_main("ev2");
    chk("ev2_stall", stall_err, 0);
    chk("ev2_cnt", EVT_CNT, 2);
    chk("ev2_err", FMT_ERR, 0);

    fifo.push_back(8'h00);
    fifo.push_back(8'h80);
    load_main();
    run(300);
    check_main("ev3");
    chk("ev3_err", FMT_ERR, 1);
    chk("ev3_cnt", EVT_CNT, 3);

    READDEPTH = 13'd0;
    fifo.push_back(8'h00);
    fifo.push_back(8'h00);
    fifo.push_back(8'h34);
    fifo.push_back(8'h0E);
    run(300);
    chk("d0_hdrcnt", hdr_cnt, 1);
    chk("d0_flag", hflag, 0);
    chk("d0_stopcell", hcell, 10'h234);
    chk("d0_nsamp", got.size(), 0);
    chk("d0_cnt", EVT_CNT, 4);
    READDEPTH = 13'd4;
    load_main();
    run(300);
    check_main("ev5");
    chk("ev5_cnt", EVT_CNT, 5);

    clr();
    load_main();
    FIFO_EMPTY = 1'b0;
    for (int i = 0; i < 300 && got.size() < 3; i++) tick();
    chk("mid_reach", got.size(), 3);
    RST = 1'b1;
    #1;
    chk("mid_rst_out", bund(), 0);
    chk("mid_rst_ovalid", u_if.OUT_VALID, 0);
    chk("mid_rst_hdr", {HDR_VALID, HDR_STOPCH_FLAG, HDR_STOPCH, HDR_STOPCELL}, 0);
    chk("mid_rst_err_cnt", {FMT_ERR, EVT_CNT}, 0);
    fifo.delete();
    FIFO_VALID = 1'b0;
    FIFO_EMPTY = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    load_main();
    run(300);
    check_main("ev6");
    chk("ev6_cnt", EVT_CNT, 1);
    chk("ev6_err", FMT_ERR, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
